// File: rtl/ibex_rf_write_arbiter.sv
// Register-file write-port arbiter: WB writes win, LSU load data bypasses or waits in an in-order buffer.
// Optional forwarding from the buffer is enabled by defining IBEX_RF_WBUF_FWD_EN.
module ibex_rf_write_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned BufDepth  = 2,
  parameter bit          RV32E     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wb_we_i,
  input  logic [4:0]           wb_waddr_i,
  input  logic [DataWidth-1:0] wb_wdata_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 pending_a_o,
  output logic                 pending_b_o,
  output logic                 fwd_a_valid_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  output logic                 fwd_b_valid_o,
  output logic [DataWidth-1:0] fwd_b_data_o,
  output logic                 buf_empty_o
);

  localparam int unsigned PtrW = $clog2(BufDepth);
  localparam int unsigned CntW = PtrW + 1;

  logic [4:0]           buf_addr_q [BufDepth];
  logic [DataWidth-1:0] buf_data_q [BufDepth];
  logic [BufDepth-1:0]  buf_valid_q;
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]      count_q;

  logic [4:0]          wb_addr, lsu_addr;
  logic                empty, full, pop, lsu_accept, bypass, push, push_valid;
  logic [BufDepth-1:0] kill;

  // RV32E has only x0..x15, so bit 4 of a write address carries no information.
  assign wb_addr  = RV32E ? {1'b0, wb_waddr_i[3:0]}  : wb_waddr_i;
  assign lsu_addr = RV32E ? {1'b0, lsu_waddr_i[3:0]} : lsu_waddr_i;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CntW'(BufDepth));
  assign buf_empty_o = empty;
  assign lsu_ready_o = rst_ni & ~full;
  assign lsu_accept  = lsu_valid_i & lsu_ready_o;
  assign pop         = rst_ni & ~wb_we_i & ~empty;
  assign bypass      = lsu_accept & ~wb_we_i & empty;
  // x0 loads are accepted and dropped; a same-cycle WB to the same register kills the entry on entry.
  assign push        = lsu_accept & ~bypass & (lsu_addr != 5'd0);
  assign push_valid  = ~(wb_we_i & (wb_addr == lsu_addr));

  always_comb begin
    kill = '0;
    for (int i = 0; i < BufDepth; i++) begin
      kill[i] = wb_we_i & (wb_addr != 5'd0) & (buf_addr_q[i] == wb_addr);
    end
  end

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = '0;
    if (rst_ni && wb_we_i) begin
      rf_we_o    = (wb_addr != 5'd0);
      rf_waddr_o = wb_addr;
      rf_wdata_o = wb_wdata_i;
    end else if (pop) begin
      rf_we_o    = buf_valid_q[rd_ptr_q] & (buf_addr_q[rd_ptr_q] != 5'd0);
      rf_waddr_o = buf_addr_q[rd_ptr_q];
      rf_wdata_o = buf_data_q[rd_ptr_q];
    end else if (bypass) begin
      rf_we_o    = (lsu_addr != 5'd0);
      rf_waddr_o = lsu_addr;
      rf_wdata_o = lsu_wdata_i;
    end
  end

  always_comb begin
    pending_a_o = 1'b0;
    pending_b_o = 1'b0;
    for (int i = 0; i < BufDepth; i++) begin
      if (buf_valid_q[i] && buf_addr_q[i] == raddr_a_i && raddr_a_i != 5'd0) pending_a_o = 1'b1;
      if (buf_valid_q[i] && buf_addr_q[i] == raddr_b_i && raddr_b_i != 5'd0) pending_b_o = 1'b1;
    end
  end

`ifdef IBEX_RF_WBUF_FWD_EN
  // Walk from head to tail so the youngest matching entry wins.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx          = '0;
    fwd_a_data_o = '0;
    fwd_b_data_o = '0;
    for (int k = 0; k < BufDepth; k++) begin
      idx = rd_ptr_q + PtrW'(k);
      if (CntW'(k) < count_q && buf_valid_q[idx]) begin
        if (buf_addr_q[idx] == raddr_a_i && raddr_a_i != 5'd0) fwd_a_data_o = buf_data_q[idx];
        if (buf_addr_q[idx] == raddr_b_i && raddr_b_i != 5'd0) fwd_b_data_o = buf_data_q[idx];
      end
    end
  end
  assign fwd_a_valid_o = pending_a_o;
  assign fwd_b_valid_o = pending_b_o;
`else
  assign fwd_a_valid_o = 1'b0;
  assign fwd_a_data_o  = '0;
  assign fwd_b_valid_o = 1'b0;
  assign fwd_b_data_o  = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BufDepth; i++) begin
        buf_addr_q[i] <= 5'd0;
        buf_data_q[i] <= '0;
      end
      buf_valid_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      for (int i = 0; i < BufDepth; i++) begin
        if (kill[i]) buf_valid_q[i] <= 1'b0;
      end
      if (pop) begin
        buf_valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q              <= rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        buf_addr_q[wr_ptr_q]  <= lsu_addr;
        buf_data_q[wr_ptr_q]  <= lsu_wdata_i;
        buf_valid_q[wr_ptr_q] <= push_valid;
        wr_ptr_q              <= wr_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Bench for ibex_rf_write_arbiter: directed scenarios plus random traffic, RF writes checked against expected queues.
module tb_ibex_rf_write_arbiter;

  localparam int W = 37;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wb_we_i, lsu_valid_i;
  logic [4:0]  wb_waddr_i, lsu_waddr_i, raddr_a_i, raddr_b_i;
  logic [31:0] wb_wdata_i, lsu_wdata_i;
  logic        lsu_ready_o, rf_we_o, pending_a_o, pending_b_o;
  logic        fwd_a_valid_o, fwd_b_valid_o, buf_empty_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o, fwd_a_data_o, fwd_b_data_o;

  logic [W-1:0] exp_wb_q[$];
  logic [W-1:0] exp_lsu_q[$];
  int n_checks = 0;
  int n_err    = 0;

  ibex_rf_write_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
    .pending_a_o(pending_a_o), .pending_b_o(pending_b_o),
    .fwd_a_valid_o(fwd_a_valid_o), .fwd_a_data_o(fwd_a_data_o),
    .fwd_b_valid_o(fwd_b_valid_o), .fwd_b_data_o(fwd_b_data_o),
    .buf_empty_o(buf_empty_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; caller inspects outputs at the following negedge.
  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    @(posedge clk_i);
    #1;
    wb_we_i     = wv;
    wb_waddr_i  = wa;
    wb_wdata_i  = wd;
    lsu_valid_i = lv;
    lsu_waddr_i = la;
    lsu_wdata_i = ld;
    if (wv && wa != 5'd0) exp_wb_q.push_back({wa, wd});
    @(negedge clk_i);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // scoreboard: every RF write is matched against the WB or LSU expected queue
  always begin
    @(negedge clk_i);
    #2;
    if (rst_ni) begin
      if (wb_we_i) begin
        if (wb_waddr_i == 5'd0) check("wb_x0_we", rf_we_o, 0);
        else if (exp_wb_q.size() == 0) check("wb_unexp", 1, 0);
        else check("wb_wr", {rf_we_o, rf_waddr_o, rf_wdata_o}, {1'b1, exp_wb_q.pop_front()});
      end else if (rf_we_o) begin
        if (exp_lsu_q.size() == 0) check("lsu_unexp", {rf_waddr_o, rf_wdata_o}, 0);
        else check("lsu_wr", {rf_waddr_o, rf_wdata_o}, exp_lsu_q.pop_front());
      end
    end
  end

  initial begin
    logic [4:0]  full_la [3];
    logic [31:0] full_ld [3];
    logic        rdy_exp [6];
    logic        hold;
    logic [4:0]  rla;
    logic [31:0] rld;
    int          idx;

    rst_ni = 1'b0;
    wb_we_i = 1'b1; wb_waddr_i = 5'd5; wb_wdata_i = 32'h1234;
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd6; lsu_wdata_i = 32'h5;
    raddr_a_i = 5'd5; raddr_b_i = 5'd6;
    repeat (2) @(negedge clk_i);
    check("rst_we", rf_we_o, 0);
    check("rst_ready", lsu_ready_o, 0);
    check("rst_empty", buf_empty_o, 1);
    check("rst_pend", {pending_a_o, pending_b_o, fwd_a_valid_o, fwd_b_valid_o}, 0);
    wb_we_i = 1'b0; lsu_valid_i = 1'b0;
    rst_ni = 1'b1;
    idle();
    check("idle_ready", lsu_ready_o, 1);
    check("idle_empty", buf_empty_o, 1);
    check("idle_we", rf_we_o, 0);

    // LSU bypass
    exp_lsu_q.push_back({5'd5, 32'hDEADBEEF});
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    check("byp_we", {rf_we_o, rf_waddr_o, rf_wdata_o}, {1'b1, 5'd5, 32'hDEADBEEF});
    idle();
    check("byp_empty", buf_empty_o, 1);

    // collision then drain
    exp_lsu_q.push_back({5'd7, 32'h22});
    raddr_a_i = 5'd7;
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    check("col_addr", rf_waddr_o, 3);
    idle();
    check("col_pend", pending_a_o, 1);
    check("col_drain", {rf_we_o, rf_waddr_o, rf_wdata_o}, {1'b1, 5'd7, 32'h22});
    idle();
    check("col_pend_clr", pending_a_o, 0);
    check("col_empty", buf_empty_o, 1);

    // full and back-pressure
    full_la = '{5'd10, 5'd11, 5'd12};
    full_ld = '{32'hA, 32'hB, 32'hC};
    rdy_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) exp_lsu_q.push_back({full_la[i], full_ld[i]});
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(c < 4, 5'(16 + c), 32'h100 + 32'(c), 1'b1, full_la[idx], full_ld[idx]);
      check($sformatf("full_rdy%0d", c), lsu_ready_o, rdy_exp[c]);
      if (lsu_ready_o && idx < 2) idx++;
    end
    idle();
    check("full_last", rf_waddr_o, 12);
    idle();
    check("full_empty", buf_empty_o, 1);

    // WAW kill of a buffered entry
    raddr_a_i = 5'd9;
    drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd9, 32'hAA);
    check("kill_acc", lsu_ready_o, 1);
    drive(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'd0);
    check("kill_pend_same", pending_a_o, 1);
    idle();
    check("kill_pop_we", rf_we_o, 0);
    check("kill_pend", {pending_a_o, fwd_a_valid_o}, 0);
    check("kill_occ", buf_empty_o, 0);
    idle();
    check("kill_empty", buf_empty_o, 1);
    // kill of an entry accepted in the same cycle
    drive(1'b1, 5'd9, 32'hCC, 1'b1, 5'd9, 32'hDD);
    idle();
    check("kill2_pop_we", rf_we_o, 0);
    check("kill2_occ", buf_empty_o, 0);
    idle();
    check("kill2_empty", buf_empty_o, 1);

    // x0 handling
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    check("x0_lsu_we", rf_we_o, 0);
    check("x0_lsu_rdy", lsu_ready_o, 1);
    drive(1'b1, 5'd21, 32'h21, 1'b1, 5'd0, 32'h66);
    idle();
    check("x0_lsu_nobuf", buf_empty_o, 1);
    exp_lsu_q.push_back({5'd6, 32'h88});
    drive(1'b1, 5'd0, 32'h77, 1'b1, 5'd6, 32'h88);
    check("x0_wb_we", rf_we_o, 0);
    idle();
    check("x0_wb_drain", rf_waddr_o, 6);

    // forwarding of the youngest matching entry
    raddr_b_i = 5'd4;
    exp_lsu_q.push_back({5'd4, 32'h1});
    exp_lsu_q.push_back({5'd4, 32'h2});
    drive(1'b1, 5'd22, 32'h22, 1'b1, 5'd4, 32'h1);
    drive(1'b1, 5'd23, 32'h23, 1'b1, 5'd4, 32'h2);
    drive(1'b1, 5'd24, 32'h24, 1'b0, 5'd0, 32'd0);
    check("fwd_pend", pending_b_o, 1);
`ifdef IBEX_RF_WBUF_FWD_EN
    check("fwd_valid", fwd_b_valid_o, 1);
    check("fwd_data", fwd_b_data_o, 32'h2);
`else
    check("fwd_off", {fwd_b_valid_o, fwd_b_data_o}, 0);
`endif
    idle();
    idle();
    idle();
    check("fwd_empty", buf_empty_o, 1);

    // random traffic: WB uses x16..x31, LSU x1..x15, so no kills occur
    hold = 1'b0; rla = 5'd0; rld = 32'd0;
    for (int c = 0; c < 300; c++) begin
      if (!hold && $urandom_range(0, 1) == 1) begin
        hold = 1'b1;
        rla  = 5'($urandom_range(1, 15));
        rld  = $urandom;
      end
      drive($urandom_range(0, 2) == 0, {1'b1, 4'($urandom_range(0, 15))}, $urandom, hold, rla, rld);
      if (hold && lsu_ready_o) begin
        exp_lsu_q.push_back({rla, rld});
        hold = 1'b0;
      end
    end
    for (int c = 0; c < 20 && !buf_empty_o; c++) idle();
    check("rnd_drain", buf_empty_o, 1);
    idle();

    check("wb_q_left", exp_wb_q.size(), 0);
    check("lsu_q_left", exp_lsu_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
